// File: rtl/pipe_cia_adder.sv
// Pipelined carry-increment adder/subtractor with valid/ready flow control.
// Each stage resolves BPS ripple blocks and hands its carry to the next stage.
module pipe_cia_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int BPS   = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);
    localparam int NBLK   = WIDTH / BLOCK;
    localparam int STAGES = (NBLK + BPS - 1) / BPS;

    logic             valid_d [STAGES];
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             carry_d [STAGES];
    logic             carry_q [STAGES];
    logic             zero_d;
    logic             zero_q;
    logic             en;

    // The whole pipe advances together; a held result freezes every stage.
    assign en       = ~valid_q[STAGES-1] | OUT_READY;
    assign IN_READY = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int FIRST = k * BPS;
        localparam int NB    = ((NBLK - FIRST) < BPS) ? (NBLK - FIRST) : BPS;
        localparam int LO    = FIRST * BLOCK;

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_out;
        logic             c_out;
        logic             rc;
        logic             ic;
        logic             raw_c;
        logic             bit_s;

        if (k == 0) begin : g_head
            assign v_in = IN_VALID;
            assign a_in = A;
            assign b_in = B ^ {WIDTH{SUB}};
            assign c_in = CIN ^ SUB;
            assign s_in = '0;
        end else begin : g_body
            assign v_in = valid_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = carry_q[k-1];
            assign s_in = sum_q[k-1];
        end

        // First block ripples with the stage carry; the others ripple from 0
        // and are then incremented by the carry of the block below them.
        always_comb begin
            s_out = s_in;
            c_out = c_in;
            rc    = 1'b0;
            ic    = 1'b0;
            raw_c = 1'b0;
            bit_s = 1'b0;
            for (int j = 0; j < NB; j++) begin
                rc = (j == 0) ? c_out : 1'b0;
                for (int i = 0; i < BLOCK; i++) begin
                    s_out[LO + j*BLOCK + i] = a_in[LO + j*BLOCK + i] ^ b_in[LO + j*BLOCK + i] ^ rc;
                    rc = (a_in[LO + j*BLOCK + i] & b_in[LO + j*BLOCK + i])
                       | (rc & (a_in[LO + j*BLOCK + i] ^ b_in[LO + j*BLOCK + i]));
                end
                raw_c = rc;
                ic    = (j == 0) ? 1'b0 : c_out;
                for (int i = 0; i < BLOCK; i++) begin
                    bit_s = s_out[LO + j*BLOCK + i];
                    s_out[LO + j*BLOCK + i] = bit_s ^ ic;
                    ic = bit_s & ic;
                end
                c_out = raw_c | ic;
            end
        end

        assign valid_d[k] = v_in;
        assign sum_d[k]   = s_out;
        assign a_d[k]     = a_in;
        assign b_d[k]     = b_in;
        assign carry_d[k] = c_out;
    end

    assign zero_d = ~|sum_d[STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                carry_q[k] <= carry_d[k];
            end
            zero_q <= zero_d;
        end
    end

    // Overflow uses the operand MSBs that travelled down with the result.
    assign OUT_VALID = valid_q[STAGES-1];
    assign SUM       = sum_q[STAGES-1];
    assign COUT      = carry_q[STAGES-1];
    assign OVF       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                    && (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    assign ZERO      = zero_q;

endmodule
